// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit with its sequencing controller.
// Owns the architectural HI/LO registers. MULT/MULTU/DIV/DIVU run with a
// fixed latency before their results land in HI/LO. MTHI/MTLO write in a
// single cycle. e_mdu_busy tells the stall unit to hold md/mt/mf ops in D.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        e_mdu_busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_tmp;
    logic [31:0]      lo_tmp;

    logic        go;
    logic        is_md;
    logic        is_div;
    logic        is_signed;
    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // A start only counts when the unit is idle and no flush kills it.
    assign go        = start && !flush && (state == IDLE);
    assign is_md     = !md_op[2];
    assign is_div    = md_op[1];
    assign is_signed = !md_op[0];

    // Busy covers the start cycle combinationally, then the whole RUN phase.
    assign e_mdu_busy = (go && is_md) || (state == RUN);

    // Full-width result for the op presented this cycle; division works on
    // magnitudes so that the most-negative / -1 case wraps to 0x80000000 cleanly.
    always_comb begin
        prod   = '0;
        a_mag  = src_a;
        b_mag  = src_b;
        q_mag  = '0;
        r_mag  = '0;
        quot   = '0;
        rem    = '0;
        res_hi = hi;
        res_lo = lo;
        if (is_signed) begin
            prod = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
            if (src_a[31]) a_mag = ~src_a + 32'd1;
            if (src_b[31]) b_mag = ~src_b + 32'd1;
        end else begin
            prod = {32'd0, src_a} * {32'd0, src_b};
        end
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (is_signed && (src_a[31] ^ src_b[31])) ? (~q_mag + 32'd1) : q_mag;
        rem  = (is_signed && src_a[31]) ? (~r_mag + 32'd1) : r_mag;
        if (!is_div) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (src_b != 32'd0) begin
            res_hi = rem;
            res_lo = quot;
        end
    end

    // Sequencer: latch the result at start, count down, commit to HI/LO at the end.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            hi_tmp <= '0;
            lo_tmp <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        case (md_op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                hi_tmp <= res_hi;
                                lo_tmp <= res_lo;
                                cnt    <= is_div ? DIV_CNT : MULT_CNT;
                                state  <= RUN;
                            end
                            3'd4:    hi <= src_a;
                            3'd5:    lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        hi    <= hi_tmp;
                        lo    <= lo_tmp;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed-vector bench for the multiply/divide unit.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        e_mdu_busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .e_mdu_busy(e_mdu_busy),
        .hi        (hi),
        .lo        (lo)
    );

    // Free-running clock; inputs change and outputs are sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic f);
        start = s;
        md_op = op;
        src_a = a;
        src_b = b;
        flush = f;
        #1;
    endtask

    // Multi-cycle op: busy from the start cycle through cycle n, result visible at n+1.
    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        checkOutput({tag, "_idle_before"}, {31'd0, e_mdu_busy}, 32'd0);
        applyStimulus(1'b1, op, a, b, 1'b0);
        checkOutput({tag, "_busy_c0"}, {31'd0, e_mdu_busy}, 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 1; i <= n; i++) begin
            checkOutput($sformatf("%s_busy_c%0d", tag, i), {31'd0, e_mdu_busy}, 32'd1);
            if (i == n) begin
                checkOutput({tag, "_hi_held"}, hi, m_hi);
                checkOutput({tag, "_lo_held"}, lo, m_lo);
            end
            @(negedge clk);
        end
        checkOutput({tag, "_busy_done"}, {31'd0, e_mdu_busy}, 32'd0);
        checkOutput({tag, "_hi"}, hi, exp_hi);
        checkOutput({tag, "_lo"}, lo, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    // Single-cycle op (MTHI/MTLO/no-op, possibly flushed): never busy.
    task automatic mtOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic f, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        applyStimulus(1'b1, op, a, 32'd0, f);
        checkOutput({tag, "_busy_c0"}, {31'd0, e_mdu_busy}, 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        checkOutput({tag, "_busy_c1"}, {31'd0, e_mdu_busy}, 32'd0);
        checkOutput({tag, "_hi"}, hi, exp_hi);
        checkOutput({tag, "_lo"}, lo, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    // Directed sequence.
    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_busy", {31'd0, e_mdu_busy}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;

        runOp("mult_neg1x2",  3'd0, 32'hFFFFFFFF, 32'd2, MULT_N, 32'hFFFFFFFF, 32'hFFFFFFFE);
        runOp("multu_maxx2",  3'd1, 32'hFFFFFFFF, 32'd2, MULT_N, 32'h00000001, 32'hFFFFFFFE);
        runOp("mult_neg3x4",  3'd0, 32'hFFFFFFFD, 32'd4, MULT_N, 32'hFFFFFFFF, 32'hFFFFFFF4);
        runOp("div_neg7_2",   3'd2, 32'hFFFFFFF9, 32'd2, DIV_N,  32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("div_7_neg2",   3'd2, 32'd7, 32'hFFFFFFFE, DIV_N,  32'h00000001, 32'hFFFFFFFD);
        runOp("div_ovf",      3'd2, 32'h80000000, 32'hFFFFFFFF, DIV_N, 32'h00000000, 32'h80000000);
        runOp("divu_100_7",   3'd3, 32'd100, 32'd7, DIV_N, 32'd2, 32'd14);
        runOp("divu_max_16",  3'd3, 32'hFFFFFFFF, 32'd16, DIV_N, 32'h0000000F, 32'h0FFFFFFF);

        mtOp("mthi", 3'd4, 32'h00000011, 1'b0, 32'h00000011, m_lo);
        mtOp("mtlo", 3'd5, 32'h00000022, 1'b0, 32'h00000011, 32'h00000022);

        runOp("divu_by0", 3'd3, 32'd5, 32'd0, DIV_N, 32'h00000011, 32'h00000022);
        runOp("div_by0",  3'd2, 32'hFFFFFFF9, 32'd0, DIV_N, 32'h00000011, 32'h00000022);

        // Flushed MULT must not start or ever commit.
        applyStimulus(1'b1, 3'd0, 32'd5, 32'd5, 1'b1);
        checkOutput("flush_mult_busy_c0", {31'd0, e_mdu_busy}, 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("flush_mult_busy_c1", {31'd0, e_mdu_busy}, 32'd0);
        repeat (MULT_N + 1) @(negedge clk);
        checkOutput("flush_mult_hi", hi, 32'h00000011);
        checkOutput("flush_mult_lo", lo, 32'h00000022);

        mtOp("flush_mthi", 3'd4, 32'h00001234, 1'b1, 32'h00000011, 32'h00000022);
        mtOp("nop6", 3'd6, 32'hDEADBEEF, 1'b0, 32'h00000011, 32'h00000022);
        mtOp("nop7", 3'd7, 32'hDEADBEEF, 1'b0, 32'h00000011, 32'h00000022);

        // Flush during RUN must not abort the committed multiply.
        checkOutput("flushrun_idle_before", {31'd0, e_mdu_busy}, 32'd0);
        applyStimulus(1'b1, 3'd1, 32'd3, 32'd5, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        checkOutput("flushrun_busy_c1", {31'd0, e_mdu_busy}, 32'd1);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("flushrun_busy_c2", {31'd0, e_mdu_busy}, 32'd1);
        repeat (MULT_N - 1) @(negedge clk);
        checkOutput("flushrun_busy_done", {31'd0, e_mdu_busy}, 32'd0);
        checkOutput("flushrun_hi", hi, 32'd0);
        checkOutput("flushrun_lo", lo, 32'd15);

        // Reset in cycle 4 of a DIV discards it; a following MTLO still works.
        applyStimulus(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rstrun_busy_c4", {31'd0, e_mdu_busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rstrun_busy_c5", {31'd0, e_mdu_busy}, 32'd0);
        checkOutput("rstrun_hi", hi, 32'd0);
        checkOutput("rstrun_lo", lo, 32'd0);
        mtOp("rst_mtlo", 3'd5, 32'h0000ABCD, 1'b0, 32'd0, 32'h0000ABCD);
        repeat (DIV_N) @(negedge clk);
        checkOutput("rstrun_late_hi", hi, 32'd0);
        checkOutput("rstrun_late_lo", lo, 32'h0000ABCD);
        checkOutput("rstrun_late_busy", {31'd0, e_mdu_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
